// File: rtl/sig_to_one_pkg.sv
// Shared widths and types for the sig_to_one lane packer.
package sig_to_one_pkg;

  localparam int WIDTH_DEF = 10;
  localparam int NUM_DEF   = 16;
  localparam int OUT_W     = WIDTH_DEF * NUM_DEF;

  typedef logic signed [WIDTH_DEF-1:0] lane_t;
  typedef logic [OUT_W-1:0]            bus_t;

  // Low bit index of lane k inside the packed bus.
  function automatic int lane_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/sig_lane_reg.sv
// One lane of the packer: WIDTH-bit enable register with async active-low clear.
module sig_lane_reg #(
  parameter int WIDTH = 10
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/sig_to_one.sv
// Packs NUM sample lanes into one registered bus on a qualified clk_fast edge.
// Optional SIG2ONE_VALID_EN adds sout_valid, high the cycle after each capture.
module sig_to_one
  import sig_to_one_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NUM   = NUM_DEF
) (
  input  logic                 clk_fast,
  input  logic                 rst_n,
  input  logic                 combine_sig_s,
  input  logic [WIDTH-1:0]     Sin0,
  input  logic [WIDTH-1:0]     Sin1,
  input  logic [WIDTH-1:0]     Sin2,
  input  logic [WIDTH-1:0]     Sin3,
  input  logic [WIDTH-1:0]     Sin4,
  input  logic [WIDTH-1:0]     Sin5,
  input  logic [WIDTH-1:0]     Sin6,
  input  logic [WIDTH-1:0]     Sin7,
  input  logic [WIDTH-1:0]     Sin8,
  input  logic [WIDTH-1:0]     Sin9,
  input  logic [WIDTH-1:0]     Sin10,
  input  logic [WIDTH-1:0]     Sin11,
  input  logic [WIDTH-1:0]     Sin12,
  input  logic [WIDTH-1:0]     Sin13,
  input  logic [WIDTH-1:0]     Sin14,
  input  logic [WIDTH-1:0]     Sin15,
`ifdef SIG2ONE_VALID_EN
  output logic                 sout_valid,
`endif
  output logic [WIDTH*NUM-1:0] Sout_s
);

  logic [WIDTH-1:0] w_lanes [16];

  assign w_lanes = '{Sin0, Sin1, Sin2, Sin3, Sin4, Sin5, Sin6, Sin7,
                     Sin8, Sin9, Sin10, Sin11, Sin12, Sin13, Sin14, Sin15};

  // Lane bits are copied verbatim; signedness is only meaningful downstream.
  for (genvar k = 0; k < NUM; k++) begin : g_lane
    sig_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk_fast (clk_fast),
      .rst_n    (rst_n),
      .i_en     (combine_sig_s),
      .i_d      (w_lanes[k]),
      .o_q      (Sout_s[lane_lo(k, WIDTH) +: WIDTH])
    );
  end

`ifdef SIG2ONE_VALID_EN
  logic r_valid;

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) r_valid <= 1'b0;
    else        r_valid <= combine_sig_s;
  end

  assign sout_valid = r_valid;
`endif

endmodule

// File: tb/tb_sig_to_one.sv
// Self-checking bench for sig_to_one: vector table plus scoreboard of expected words.
module tb_sig_to_one;
  import sig_to_one_pkg::*;

  logic clk_fast = 1'b0;
  logic rst_n    = 1'b1;
  logic combine_sig_s = 1'b0;
  logic [WIDTH_DEF-1:0] lanes [NUM_DEF];
  bus_t Sout_s;
`ifdef SIG2ONE_VALID_EN
  logic sout_valid;
`endif

  typedef struct {
    bus_t bus;
    logic vld;
  } exp_t;

  typedef struct {
    logic [WIDTH_DEF-1:0] l [NUM_DEF];
    logic cap;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[5];
  bus_t model_bus = '0;
  int n_cmp = 0;
  int n_bad = 0;

  sig_to_one dut (
    .clk_fast      (clk_fast),
    .rst_n         (rst_n),
    .combine_sig_s (combine_sig_s),
    .Sin0  (lanes[0]),  .Sin1  (lanes[1]),  .Sin2  (lanes[2]),  .Sin3  (lanes[3]),
    .Sin4  (lanes[4]),  .Sin5  (lanes[5]),  .Sin6  (lanes[6]),  .Sin7  (lanes[7]),
    .Sin8  (lanes[8]),  .Sin9  (lanes[9]),  .Sin10 (lanes[10]), .Sin11 (lanes[11]),
    .Sin12 (lanes[12]), .Sin13 (lanes[13]), .Sin14 (lanes[14]), .Sin15 (lanes[15]),
`ifdef SIG2ONE_VALID_EN
    .sout_valid    (sout_valid),
`endif
    .Sout_s        (Sout_s)
  );

  always #5 clk_fast = ~clk_fast;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic bus_t pack(input logic [WIDTH_DEF-1:0] l [NUM_DEF]);
    bus_t b = '0;
    for (int k = 0; k < NUM_DEF; k++) b[k*WIDTH_DEF +: WIDTH_DEF] = l[k];
    return b;
  endfunction

  task automatic chk(input string nm, input bus_t act, input bus_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got empty scoreboard want one entry", nm);
      return;
    end
    e = sb.pop_front();
    chk(nm, Sout_s, e.bus);
`ifdef SIG2ONE_VALID_EN
    chk({nm, "_valid"}, bus_t'(sout_valid), bus_t'(e.vld));
`endif
  endtask

  // Drive between edges, predict, then compare just after the capturing edge.
  task automatic step(input string nm, input logic [WIDTH_DEF-1:0] l [NUM_DEF], input logic cap);
    exp_t e;
    @(negedge clk_fast);
    for (int k = 0; k < NUM_DEF; k++) lanes[k] = l[k];
    combine_sig_s = cap;
    if (cap) model_bus = pack(l);
    e.bus = model_bus;
    e.vld = cap;
    sb.push_back(e);
    @(posedge clk_fast);
    #1;
    chk_out(nm);
  endtask

  initial begin
    int spec_l [NUM_DEF] = '{160, -2, -4, -2, 156, -6, -4, -12,
                             164, -2, -4, -2, 164, -4, -12, 164};
    logic [WIDTH_DEF-1:0] w [NUM_DEF];
    bus_t zero_bus = '0;

    for (int k = 0; k < NUM_DEF; k++) begin
      tbl[0].l[k] = WIDTH_DEF'(spec_l[k]);
      lanes[k]    = WIDTH_DEF'(k * 37 + 3);
    end
    tbl[0].cap = 1'b0;
    tbl[1]     = tbl[0];
    tbl[2]     = tbl[0];
    tbl[2].cap = 1'b1;
    tbl[3]     = tbl[0];
    tbl[3].l[0] = 10'd5;
    tbl[4]     = tbl[3];
    tbl[4].cap = 1'b1;

    // Reset with clock running, nonzero lanes and capture requested.
    combine_sig_s = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("rst_immediate", Sout_s, zero_bus);
    repeat (3) @(posedge clk_fast);
    #1 chk("rst_held", Sout_s, zero_bus);
`ifdef SIG2ONE_VALID_EN
    chk("rst_valid", bus_t'(sout_valid), zero_bus);
`endif
    @(negedge clk_fast);
    combine_sig_s = 1'b0;
    rst_n = 1'b1;
    model_bus = '0;

    for (int i = 0; i < 5; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].l, tbl[i].cap);
      if (i == 2) begin
        chk("slice0",  bus_t'(Sout_s[9:0]),     bus_t'(10'h0A0));
        chk("slice1",  bus_t'(Sout_s[19:10]),   bus_t'(10'h3FE));
        chk("slice2",  bus_t'(Sout_s[29:20]),   bus_t'(10'h3FC));
        chk("slice4",  bus_t'(Sout_s[49:40]),   bus_t'(10'h09C));
        chk("slice5",  bus_t'(Sout_s[59:50]),   bus_t'(10'h3FA));
        chk("slice7",  bus_t'(Sout_s[79:70]),   bus_t'(10'h3F4));
        chk("slice8",  bus_t'(Sout_s[89:80]),   bus_t'(10'h0A4));
        chk("slice15", bus_t'(Sout_s[159:150]), bus_t'(10'h0A4));
      end
    end
    chk("sin0_new", bus_t'(Sout_s[9:0]), bus_t'(10'h005));

    // Lanes wiggling between edges must not leak through.
    @(negedge clk_fast);
    combine_sig_s = 1'b0;
    for (int k = 0; k < NUM_DEF; k++) lanes[k] = ~lanes[k];
    #2 chk("no_comb_path", Sout_s, model_bus);

    // Async reset between edges, then reset held across a capture edge.
    #1 rst_n = 1'b0;
    #1 chk("async_rst", Sout_s, zero_bus);
    combine_sig_s = 1'b1;
    @(posedge clk_fast);
    #1 chk("rst_beats_cap", Sout_s, zero_bus);
    @(negedge clk_fast);
    combine_sig_s = 1'b0;
    rst_n = 1'b1;
    model_bus = '0;

    // Continuous capture with rotating walking-ones pattern.
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < NUM_DEF; k++) w[k] = WIDTH_DEF'(1) << ((k + c) % WIDTH_DEF);
      step($sformatf("cont%0d", c), w, 1'b1);
    end
    for (int k = 0; k < NUM_DEF; k++) w[k] = 10'h155;
    step("hold_after_cont", w, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sig_to_one.md
Name: sig_to_one

Overview:
- Parallel-to-bus packer in the parallel JPEG-2000 datapath.
- Captures NUM signed sample lanes (10-bit lifting-stage results Sin0..Sin15) into one wide registered bus Sout_s.
- Capture happens on a clk_fast edge qualified by combine_sig_s.
- Downstream logic (SDRAM/SPI writer) consumes Sout_s as a single word.

Parameters:
- WIDTH, 10, bit width of each input lane (two's-complement sample).
- NUM, 16, number of input lanes; Sout_s width = WIDTH*NUM.

Ports:
- clk_fast  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- combine_sig_s  input  1  capture enable, sampled on rising clk_fast.
- Sin0 .. Sin15  input  WIDTH each  lane samples, two's complement; SinK is lane K.
- Sout_s  output  WIDTH*NUM (160)  registered packed bus.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk_fast, rst_n).
- Reset:
  - rst_n low forces Sout_s to 0 immediately, independent of clk_fast.
  - Sout_s stays 0 while rst_n is low.
  - Release of rst_n takes effect at the next rising edge.
- Packing: lane K occupies Sout_s[WIDTH*K+WIDTH-1 : WIDTH*K].
  - Sin0 sits at [9:0]; Sin15 sits at [159:150].
  - Bits are copied verbatim: no sign extension, no arithmetic, no reordering.
- Capture:
  - Rising clk_fast with combine_sig_s=1: Sout_s takes the current values of all NUM lanes, all simultaneously.
  - Latency is 1 edge; there is no combinational path from any input to Sout_s.
- Hold:
  - combine_sig_s=0 at the edge: Sout_s retains its previous value.
  - Lane changes between edges have no effect on the output.
- Continuous mode: combine_sig_s held high captures on every edge, one fresh word per cycle.
- No handshake or backpressure; no partial-lane update.
- Reset asserted together with a capture edge: reset wins, Sout_s=0.

Optional Feature:
- Macro: SIG2ONE_VALID_EN.
- Defined:
  - Adds output port sout_valid (1 bit).
  - sout_valid is registered: 1 for exactly the cycle after each capture edge, otherwise 0.
  - Continuous capture keeps it high.
  - Reset value 0.
- Undefined: port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package sig_to_one_pkg holds:
  - WIDTH_DEF=10, NUM_DEF=16, OUT_W=WIDTH_DEF*NUM_DEF;
  - typedef lane_t (signed [WIDTH-1:0]);
  - typedef bus_t ([OUT_W-1:0]).
- One natural sub-module, sig_lane_reg: a WIDTH-bit enable register with async active-low clear.
  - Instantiate NUM times via generate, lane K driving slice K.

Test Plan:
- Reset: rst_n=0 with nonzero inputs and clock toggling -> Sout_s=0; deassert with combine_sig_s=0 -> still 0.
- Hold: lanes = 160,-2,-4,-2,156,-6,-4,-12,164,-2,-4,-2,164,-4,-12,164 with combine_sig_s=0 over several edges -> Sout_s stays 0.
- Single capture: same lanes, combine_sig_s=1 for one edge. Expected slices:
  - [9:0]=0x0A0, [19:10]=0x3FE, [29:20]=0x3FC, [49:40]=0x09C;
  - [59:50]=0x3FA, [79:70]=0x3F4, [89:80]=0x0A4, [159:150]=0x0A4.
- Hold after capture: change Sin0 to 5 with combine_sig_s=0 -> Sout_s unchanged. Next edge with combine_sig_s=1 -> [9:0]=0x005.
- Async reset mid-operation: assert rst_n low between edges after a capture -> Sout_s=0 before the next edge.
- Continuous mode: walking-ones lane K = 1<<(K mod 10), combine_sig_s held high -> each edge reflects the current lanes. With SIG2ONE_VALID_EN, sout_valid is high from the cycle after the first capture.
